// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES controller frame sequencer.
// The byte helpers encode the wire format: buttons are active-low and the high nibble is padded with ones.
package snes_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    LATCHED  = 2'd1,
    SHIFT_LO = 2'd2,
    SHIFT_HI = 2'd3
  } state_t;

  localparam int BTN_B      = 0;
  localparam int BTN_Y      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;
  localparam int BTN_A      = 8;
  localparam int BTN_X      = 9;
  localparam int BTN_L      = 10;
  localparam int BTN_R      = 11;

  localparam int         FRAME_BITS = 16;
  localparam int         BYTE_BITS  = 8;
  localparam logic [3:0] PAD_NIBBLE = 4'hF;

  function automatic logic [7:0] byte0(input logic [7:0] btn_lo);
    return ~btn_lo;
  endfunction

  function automatic logic [7:0] byte1(input logic [3:0] btn_hi);
    return {PAD_NIBBLE, ~btn_hi};
  endfunction

endpackage

// File: rtl/snes_sync_edge.sv
// Multi-stage synchroniser for an asynchronous console line with rising-edge detect.
// rise_pulse is combinational so the sequencer can register its response one cycle later.
module snes_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic async_in,
  output logic sync_out,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync_out   = r_sync[SYNC_STAGES-1];
  assign rise_pulse = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/snes_frame_sequencer.sv
// Turns console latch/clock edges into load and shift commands for the SNES shift-register encoder.
// A watchdog abandons frames whose console clock goes silent.
module snes_frame_sequencer
  import snes_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             snes_latch,
  input  logic             snes_clk,
  input  logic [11:0]      buttons,
  output logic             enc_load,
  output logic             enc_shift,
  output logic [7:0]       enc_d,
  output logic             busy,
  output logic [CNT_W-1:0] bit_index,
  output logic             frame_done,
  output logic             timeout
);

  localparam int WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic             w_latch_sync;
  logic             w_latch_rise;
  logic             w_clk_rise;
  logic [CNT_W-1:0] w_next_idx;

  state_t           r_state;
  logic [3:0]       r_snap_hi;
  logic [WD_W-1:0]  r_wd;
  logic             r_load;
  logic             r_shift;
  logic [7:0]       r_d;
  logic             r_busy;
  logic [CNT_W-1:0] r_idx;
  logic             r_done;
  logic             r_to;

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_latch_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (snes_latch),
    .sync_out   (w_latch_sync),
    .rise_pulse (w_latch_rise)
  );

  snes_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clock      (clock),
    .reset      (reset),
    .async_in   (snes_clk),
    .sync_out   (),
    .rise_pulse (w_clk_rise)
  );

  assign w_next_idx = r_idx + CNT_W'(1);

  // Frame FSM; latch rise pre-empts everything, including a coincident clock edge.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_snap_hi <= 4'h0;
      r_wd      <= '0;
      r_load    <= 1'b0;
      r_shift   <= 1'b0;
      r_d       <= 8'h00;
      r_busy    <= 1'b0;
      r_idx     <= '0;
      r_done    <= 1'b0;
      r_to      <= 1'b0;
    end else begin
      r_load  <= 1'b0;
      r_shift <= 1'b0;
      r_done  <= 1'b0;
      r_to    <= 1'b0;
      if (w_latch_rise) begin
        r_snap_hi <= buttons[BTN_R:BTN_A];
        r_d       <= byte0(buttons[BTN_RIGHT:BTN_B]);
        r_load    <= 1'b1;
        r_idx     <= '0;
        r_busy    <= 1'b1;
        r_wd      <= '0;
        r_state   <= LATCHED;
      end else begin
        if (w_clk_rise || !r_busy) begin
          r_wd <= '0;
        end else begin
          r_wd <= r_wd + WD_W'(1);
        end
        case (r_state)
          IDLE: begin
            r_state <= IDLE;
          end
          LATCHED: begin
            if (!w_latch_sync) begin
              r_state <= SHIFT_LO;
            end else begin
              r_state <= LATCHED;
            end
          end
          SHIFT_LO: begin
            if (w_clk_rise) begin
              r_idx <= w_next_idx;
              if (w_next_idx == CNT_W'(BYTE_BITS)) begin
                r_d     <= byte1(r_snap_hi);
                r_load  <= 1'b1;
                r_state <= SHIFT_HI;
              end else begin
                r_shift <= 1'b1;
              end
            end
          end
          SHIFT_HI: begin
            if (w_clk_rise) begin
              r_idx   <= w_next_idx;
              r_shift <= 1'b1;
              if (w_next_idx == CNT_W'(FRAME_BITS)) begin
                r_done  <= 1'b1;
                r_busy  <= 1'b0;
                r_state <= IDLE;
              end
            end
          end
          default: begin
            r_state <= IDLE;
          end
        endcase
        // Watchdog expiry; only reachable when no clock edge arrived this cycle.
        if (r_busy && !w_clk_rise && (r_wd == WD_W'(TIMEOUT_CYCLES - 1))) begin
          r_to    <= 1'b1;
          r_busy  <= 1'b0;
          r_wd    <= '0;
          r_state <= IDLE;
        end
      end
    end
  end

  assign enc_load   = r_load;
  assign enc_shift  = r_shift;
  assign enc_d      = r_d;
  assign busy       = r_busy;
  assign bit_index  = r_idx;
  assign frame_done = r_done;
  assign timeout    = r_to;

endmodule

// File: tb/tb_snes_frame_sequencer.sv
// Self-checking bench: records every DUT pulse and compares it with a frame-level reference
// built from the button snapshot and the number of console clock rises.
module tb_snes_frame_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        snes_latch = 1'b0;
  logic        snes_clk = 1'b0;
  logic [11:0] buttons = 12'h000;
  logic        enc_load, enc_shift, busy, frame_done, timeout;
  logic [7:0]  enc_d;
  logic [4:0]  bit_index;

  typedef struct {
    bit         ld;
    bit         sh;
    logic [7:0] d;
    logic [4:0] idx;
    bit         done;
    bit         to;
    int         cyc;
  } ev_t;

  ev_t  ev_q[$];
  ev_t  exp_q[$];
  bit   ser_q[$];
  logic [7:0] enc_reg = 8'hFF;
  int   cyc = 0;
  int   t_latch = 0;
  int   n_vec = 0;
  int   n_err = 0;

  snes_frame_sequencer #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(64), .CNT_W(5)) dut (
    .clock(clock), .reset(reset), .snes_latch(snes_latch), .snes_clk(snes_clk),
    .buttons(buttons), .enc_load(enc_load), .enc_shift(enc_shift), .enc_d(enc_d),
    .busy(busy), .bit_index(bit_index), .frame_done(frame_done), .timeout(timeout)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture pulses and run a behavioural encoder on the falling edge.
  always @(negedge clock) begin
    ev_t e;
    if (reset) begin
      chk("load_shift_exclusive", {31'd0, enc_load & enc_shift}, 32'd0);
      if (enc_load || enc_shift || frame_done || timeout) begin
        e.ld = enc_load; e.sh = enc_shift; e.d = enc_d; e.idx = bit_index;
        e.done = frame_done; e.to = timeout; e.cyc = cyc;
        ev_q.push_back(e);
        if (enc_load) enc_reg = enc_d;
        else if (enc_shift) enc_reg = {1'b1, enc_reg[7:1]};
        if (enc_load || enc_shift) ser_q.push_back(enc_reg[0]);
      end
    end else begin
      enc_reg = 8'hFF;
    end
  end

  function automatic logic [31:0] pack(input ev_t e);
    return {14'd0, e.ld, e.sh, e.done, e.to, e.idx, (e.ld ? e.d : 8'h00), 1'b0};
  endfunction

  // Reference: a latch loads byte 0, then each clock rise k shifts, except k=8 which loads byte 1.
  task automatic add_frame(input logic [11:0] b, input int n);
    ev_t e;
    e = '{ld: 1'b1, sh: 1'b0, d: ~b[7:0], idx: 5'd0, done: 1'b0, to: 1'b0, cyc: 0};
    exp_q.push_back(e);
    for (int k = 1; k <= n; k++) begin
      e.ld = (k == 8); e.sh = (k != 8); e.idx = 5'(k); e.done = (k == 16);
      e.d = (k == 8) ? {4'hF, ~b[11:8]} : 8'h00;
      exp_q.push_back(e);
    end
  endtask

  task automatic add_timeout(input int idx);
    ev_t e;
    e = '{ld: 1'b0, sh: 1'b0, d: 8'h00, idx: 5'(idx), done: 1'b0, to: 1'b1, cyc: 0};
    exp_q.push_back(e);
  endtask

  task automatic check_events(input string tag);
    chk({tag, "_count"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < ev_q.size() && i < exp_q.size(); i++)
      chk($sformatf("%s_ev%0d", tag, i), pack(ev_q[i]), pack(exp_q[i]));
    ev_q.delete(); exp_q.delete(); ser_q.delete();
  endtask

  task automatic latch_pulse(input logic [11:0] b);
    buttons = b; snes_latch = 1'b1; t_latch = cyc;
    repeat (4) @(negedge clock);
    snes_latch = 1'b0;
    repeat (4) @(negedge clock);
  endtask

  task automatic clk_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      snes_clk = 1'b1;
      repeat ($urandom_range(2, 5)) @(negedge clock);
      snes_clk = 1'b0;
      repeat ($urandom_range(2, 5)) @(negedge clock);
    end
  endtask

  task automatic settle();
    repeat (8) @(negedge clock);
  endtask

  initial begin
    logic [11:0] b, b2;
    logic [15:0] stream;
    int          i_shift3;

    // Reset held low while the console lines toggle.
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      snes_latch = ~snes_latch; snes_clk = ~snes_clk;
      @(negedge clock);
      chk("reset_outputs", {13'd0, enc_load, enc_shift, enc_d, busy, bit_index, frame_done, timeout}, 32'd0);
    end
    snes_latch = 1'b0; snes_clk = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    settle();
    chk("post_reset_no_events", 32'(ev_q.size()), 32'd0);

    // Full frame with only B pressed.
    latch_pulse(12'h001);
    clk_pulses(16);
    settle();
    chk("first_load_latency", 32'(ev_q[0].cyc - t_latch), 32'd3);
    chk("byte0_b", {24'd0, ev_q[0].d}, 32'h0000_00FE);
    chk("byte1_b", {24'd0, ev_q[8].d}, 32'h0000_00FF);
    for (int i = 0; i < 16; i++) chk($sformatf("serial_bit%0d", i), {31'd0, ser_q[i]}, (i == 0) ? 32'd0 : 32'd1);
    chk("bit_index_16", {27'd0, bit_index}, 32'd16);
    chk("busy_after_frame", {31'd0, busy}, 32'd0);
    add_frame(12'h001, 16);
    check_events("full_b");

    // High nibble padding and immunity to button changes mid-frame.
    latch_pulse(12'hF00);
    buttons = 12'h000;
    clk_pulses(16);
    settle();
    chk("byte1_pad", {24'd0, ev_q[8].d}, 32'h0000_00F0);
    add_frame(12'hF00, 16);
    check_events("pad");

    // Restart after five rises.
    b = 12'($urandom); b2 = 12'($urandom);
    latch_pulse(b);
    clk_pulses(5);
    latch_pulse(b2);
    clk_pulses(16);
    settle();
    add_frame(b, 5);
    add_frame(b2, 16);
    check_events("restart");

    // Latch and clock rise together: the latch wins.
    b = 12'($urandom); b2 = 12'($urandom);
    latch_pulse(b);
    clk_pulses(3);
    buttons = b2; snes_latch = 1'b1; snes_clk = 1'b1;
    repeat (4) @(negedge clock);
    chk("simul_bit_index", {27'd0, bit_index}, 32'd0);
    snes_latch = 1'b0; snes_clk = 1'b0;
    repeat (4) @(negedge clock);
    clk_pulses(16);
    settle();
    add_frame(b, 3);
    add_frame(b2, 16);
    check_events("simultaneous");

    // Watchdog: three rises then silence.
    b = 12'($urandom);
    latch_pulse(b);
    clk_pulses(3);
    repeat (80) @(negedge clock);
    i_shift3 = 3;
    if (ev_q.size() == 5) chk("timeout_delay", 32'(ev_q[4].cyc - ev_q[i_shift3].cyc), 32'd64);
    else chk("timeout_event_count", 32'(ev_q.size()), 32'd5);
    chk("busy_after_timeout", {31'd0, busy}, 32'd0);
    add_frame(b, 3);
    add_timeout(3);
    check_events("timeout");
    clk_pulses(3);
    settle();
    check_events("idle_after_timeout");

    // Reset in the middle of a frame.
    b = 12'($urandom);
    latch_pulse(b);
    clk_pulses(5);
    add_frame(b, 5);
    check_events("pre_reset");
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("midframe_reset_outputs", {13'd0, enc_load, enc_shift, enc_d, busy, bit_index, frame_done, timeout}, 32'd0);
    reset = 1'b1;
    clk_pulses(3);
    settle();
    check_events("idle_after_reset");

    // Randomised frames with random mid-frame button churn.
    for (int f = 0; f < 6; f++) begin
      b = 12'($urandom);
      latch_pulse(b);
      buttons = 12'($urandom);
      clk_pulses(16);
      settle();
      stream = {4'hF, ~b};
      for (int i = 0; i < 16 && i < ser_q.size(); i++)
        chk($sformatf("rand%0d_serial%0d", f, i), {31'd0, ser_q[i]}, {31'd0, stream[i]});
      chk($sformatf("rand%0d_bit_index", f), {27'd0, bit_index}, 32'd16);
      add_frame(b, 16);
      check_events($sformatf("rand%0d", f));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit expired");
  end

endmodule
